// File: rtl/x_dl_pkg.sv
// Shared definitions for the delay-line sampling protocol (host and x_driver side).
// Holds the FSM state encoding and the default command and timing constants.
package x_dl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dl_state_t;

    localparam logic [7:0] DL_CMD     = 8'h53;
    localparam int         DL_BYTES   = 4;
    // About 40 ms at 50 MHz: generous against a 115200 baud byte time of ~4340 cycles.
    localparam int         DL_TIMEOUT = 2_000_000;

endpackage

// File: rtl/x_dl_host_timer.sv
// Loadable, clearable saturating counter; o_expire flags that the next
// increment would reach P_LIMIT.
module x_dl_host_timer #(
    parameter int P_LIMIT = 16,
    localparam int W = $clog2(P_LIMIT + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    output logic         o_expire
);

    localparam logic [W-1:0] LIMIT = W'(P_LIMIT);
    localparam logic [W-1:0] LAST  = W'(P_LIMIT - 1);

    logic [W-1:0] count;

    // Clear and load take priority, so an expiry can never coincide with either.
    assign o_expire = i_inc && !i_clr && !i_load && (count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_clr) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/x_dl_host.sv
// Host-side engine: sends one sample command over a UART tx, collects the
// P_BYTES response LSB first and presents it with a one-cycle valid.
module x_dl_host
    import x_dl_pkg::*;
#(
    parameter logic [7:0] P_CMD     = DL_CMD,
    parameter int         P_BYTES   = DL_BYTES,
    parameter int         P_TIMEOUT = DL_TIMEOUT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    output logic                 o_busy,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_accept,
    input  logic                 i_rx_valid,
    input  logic [7:0]           i_rx_data,
    output logic                 o_valid,
    output logic [8*P_BYTES-1:0] o_data,
    output logic                 o_timeout
);

    localparam int              CW        = $clog2(P_BYTES + 1);
    localparam int              TW        = $clog2(P_TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_BYTE = CW'(P_BYTES - 1);

    dl_state_t     state;
    logic [CW-1:0] count;
    logic          tmr_clr;
    logic          tmr_inc;
    logic          tmr_expire;

    // Silence is only measured in WAIT; a received byte restarts the window.
    assign tmr_clr = (state != WAIT) || i_rx_valid;
    assign tmr_inc = (state == WAIT);

    x_dl_host_timer #(
        .P_LIMIT (P_TIMEOUT)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (tmr_clr),
        .i_load     (1'b0),
        .i_load_val ({TW{1'b0}}),
        .i_inc      (tmr_inc),
        .o_expire   (tmr_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            count      <= '0;
            o_busy     <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_timeout  <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        state      <= SEND;
                        o_busy     <= 1'b1;
                        o_tx_valid <= 1'b1;
                        o_tx_data  <= P_CMD;
                    end
                end
                SEND: begin
                    if (i_tx_accept) begin
                        state      <= WAIT;
                        o_tx_valid <= 1'b0;
                        count      <= '0;
                    end
                end
                WAIT: begin
                    if (i_rx_valid) begin
                        for (int k = 0; k < P_BYTES; k++) begin
                            if (count == CW'(k)) begin
                                o_data[8*k +: 8] <= i_rx_data;
                            end
                        end
                        count <= count + 1'b1;
                        if (count == LAST_BYTE) begin
                            state   <= DONE;
                            o_valid <= 1'b1;
                        end
                    end else if (tmr_expire) begin
                        state     <= IDLE;
                        o_busy    <= 1'b0;
                        o_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_dl_host.sv
// Directed bench for x_dl_host: cycle model of the protocol checked every
// cycle, plus a word scoreboard and hand-computed timing expectations.
module tb_x_dl_host;

    localparam int BYTES   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        tx_accept = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        busy;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        valid;
    logic [31:0] data;
    logic        timeout;

    int vectors = 0;
    int miscompares = 0;

    x_dl_host #(
        .P_CMD     (8'h53),
        .P_BYTES   (BYTES),
        .P_TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .o_busy      (busy),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_accept (tx_accept),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_valid     (valid),
        .o_data      (data),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the host must be doing, in protocol terms.
    bit          m_busy = 0;
    bit          m_cmd_out = 0;
    bit          m_valid = 0;
    bit          m_timeout = 0;
    int          m_got = 0;
    int          m_silence = 0;
    logic [31:0] m_word = '0;

    logic [31:0] exp_q[$];
    int          n_tx = 0;
    int          n_valid = 0;
    int          n_timeout = 0;

    always @(posedge clk) begin
        bit finishing;
        if (!rst_n) begin
            m_busy = 0; m_cmd_out = 0; m_valid = 0; m_timeout = 0;
            m_got = 0; m_silence = 0; m_word = '0;
        end else begin
            if (tx_valid && tx_accept) n_tx++;
            finishing = m_valid;
            m_valid = 0;
            m_timeout = 0;
            if (!m_busy) begin
                if (req) begin
                    m_busy = 1;
                    m_cmd_out = 1;
                end
            end else if (m_cmd_out) begin
                if (tx_accept) begin
                    m_cmd_out = 0;
                    m_got = 0;
                    m_silence = 0;
                end
            end else if (finishing) begin
                m_busy = 0;
            end else if (rx_valid) begin
                m_word[8*m_got +: 8] = rx_data;
                m_got++;
                m_silence = 0;
                if (m_got == BYTES) m_valid = 1;
            end else begin
                m_silence++;
                if (m_silence == TIMEOUT) begin
                    m_timeout = 1;
                    m_busy = 0;
                end
            end
        end
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_cmd_out});
        check("valid", {31'd0, valid}, {31'd0, m_valid});
        check("timeout", {31'd0, timeout}, {31'd0, m_timeout});
        if (m_cmd_out) check("tx_data", {24'd0, tx_data}, 32'h53);
        if (m_valid) check("data_model", data, m_word);
        if (timeout) n_timeout++;
        if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", data, 32'hxxxxxxxx);
            end else begin
                check("sb_word", data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_req();
        req = 1'b1;
        cyc(1);
        req = 1'b0;
    endtask

    task automatic accept_after(input int n);
        int k = 0;
        while (!tx_valid && k < 50) begin
            cyc(1);
            k++;
        end
        if (!tx_valid) check("tx_valid_wait_bound", {31'd0, tx_valid}, 32'd1);
        cyc(n);
        tx_accept = 1'b1;
        cyc(1);
        tx_accept = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        cyc(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_data", data, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Basic sample: accept after 3 cycles of valid
        exp_q.push_back(32'h44332211);
        send_req();
        check("busy_after_req", {31'd0, busy}, 32'd1);
        accept_after(3);
        send_byte(8'h11); cyc(2);
        send_byte(8'h22); cyc(2);
        send_byte(8'h33); cyc(2);
        send_byte(8'h44);
        check("basic_valid_latency", {31'd0, valid}, 32'd1);
        check("basic_word", data, 32'h44332211);
        cyc(1);
        check("basic_valid_single", {31'd0, valid}, 32'd0);
        check("basic_idle", {31'd0, busy}, 32'd0);
        cyc(3);

        // Back-pressure on the command byte
        exp_q.push_back(32'hDDCCBBAA);
        send_req();
        accept_after(500);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        cyc(3);

        // Timeout after two bytes
        send_req();
        accept_after(0);
        send_byte(8'h55); cyc(3);
        send_byte(8'h66);
        k = 0;
        while (!timeout && k < 40) begin
            cyc(1);
            k++;
        end
        check("timeout_distance", k, 32'd16);
        check("timeout_busy_low", {31'd0, busy}, 32'd0);
        cyc(1);
        check("timeout_single", {31'd0, timeout}, 32'd0);
        cyc(3);

        // Byte arriving on the expiry cycle wins
        exp_q.push_back(32'hD4C3B2A1);
        send_req();
        accept_after(1);
        send_byte(8'hA1);
        send_byte(8'hB2);
        cyc(15);
        send_byte(8'hC3);
        check("coincide_no_timeout", {31'd0, timeout}, 32'd0);
        check("coincide_busy", {31'd0, busy}, 32'd1);
        cyc(3);
        send_byte(8'hD4);
        check("coincide_word", data, 32'hD4C3B2A1);
        cyc(3);

        // Stray bytes in IDLE, request held through the transaction
        exp_q.push_back(32'h04030201);
        send_byte(8'hEE); send_byte(8'hFF);
        req = 1'b1;
        cyc(1);
        accept_after(1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        req = 1'b0;
        send_byte(8'h04);
        check("stray_word", data, 32'h04030201);
        cyc(3);

        // Reset in WAIT after two bytes
        send_req();
        accept_after(0);
        send_byte(8'h77); send_byte(8'h88);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_timeout", {31'd0, timeout}, 32'd0);
        check("midrst_data", data, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        exp_q.push_back(32'h9A78563C);
        send_req();
        accept_after(2);
        send_byte(8'h3C); send_byte(8'h56); send_byte(8'h78); send_byte(8'h9A);
        cyc(5);

        check("total_commands", n_tx, 32'd7);
        check("total_samples", n_valid, 32'd5);
        check("total_timeouts", n_timeout, 32'd1);
        check("sb_leftover", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
